kbd_scan_fifo: RTL and testbench



---
 rtl/kbd_scan_fifo_pkg.sv | 27 ++
 rtl/kbd_scan_fifo_ps2_rx.sv | 111 +++++++++++
 rtl/kbd_scan_fifo.sv | 126 ++++++++++++
 tb/tb_kbd_scan_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_scan_fifo_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
// Combinational definitions only: no latency, no flow control.
package kbd_scan_fifo_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } pfx_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         KBD_VALID_BIT  = 15;
  localparam int         KBD_OVF_BIT    = 14;

  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/kbd_scan_fifo_ps2_rx.sv
// PS/2 deserialiser: byte_rdy pulses one cycle after the synchronised stop-bit fall; no backpressure.
// KBD_PARITY_CHECK_EN: drop odd-parity failures and pulse par_err instead of byte_rdy.
module kbd_scan_fifo_ps2_rx
  import kbd_scan_fifo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_rdy,
  output logic [7:0] byte_dat,
  output logic       par_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_q, to_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic          par_err_q, par_err_d;
`ifdef KBD_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif
  logic          fall;
  logic          din;

  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    fall       = clk_sync_q[2] & ~clk_sync_q[1];
    din        = dat_sync_q[1];
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    to_d       = to_q;
    byte_rdy_d = 1'b0;
    par_err_d  = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
    par_d      = par_q;
`endif
    if (fall) begin
      to_d = '0;
      if (cnt_q == 4'd0) begin
        if (!din) cnt_d = 4'd1;
      end else if (cnt_q <= 4'd8) begin
        shift_d = {din, shift_q[7:1]};
        cnt_d   = cnt_q + 4'd1;
      end else if (cnt_q == 4'd9) begin
`ifdef KBD_PARITY_CHECK_EN
        par_d = din;
`endif
        cnt_d = 4'd10;
      end else begin
        cnt_d = 4'd0;
        if (din) begin
`ifdef KBD_PARITY_CHECK_EN
          if (odd_parity_ok(shift_q, par_q)) byte_rdy_d = 1'b1;
          else                               par_err_d  = 1'b1;
`else
          byte_rdy_d = 1'b1;
`endif
        end
      end
    end else if (cnt_q != 4'd0) begin
      // A stalled partial frame is abandoned so the next start bit resyncs.
      if (to_q == TW'(TIMEOUT_CYCLES)) begin
        cnt_d = 4'd0;
        to_d  = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      cnt_q      <= '0;
      shift_q    <= '0;
      to_q       <= '0;
      byte_rdy_q <= 1'b0;
      par_err_q  <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      to_q       <= to_d;
      byte_rdy_q <= byte_rdy_d;
      par_err_q  <= par_err_d;
`ifdef KBD_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign byte_rdy = byte_rdy_q;
  assign byte_dat = shift_q;
  assign par_err  = par_err_q;

endmodule

// File: rtl/kbd_scan_fifo.sv
// PS/2 key-event FIFO: key_valid two cycles after the stop-bit fall; full FIFO drops pushes and sets ovf.
// KBD_PARITY_CHECK_EN: parity failures also set ovf.
module kbd_scan_fifo
  import kbd_scan_fifo_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic        clr_ovf,
  output logic [15:0] key_data,
  output logic        key_valid,
  output logic        ovf
);

  localparam int AW = $clog2(DEPTH);

  logic       byte_rdy;
  logic [7:0] byte_dat;
  logic       par_err;

  kbd_scan_fifo_ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_rdy (byte_rdy),
    .byte_dat (byte_dat),
    .par_err  (par_err)
  );

  pfx_state_t state_q, state_d;
  logic       push;
  kbd_event_t push_ev;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    push_ev = '0;
    if (byte_rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_dat == PS2_PREFIX_EXT)      state_d = ST_E0;
          else if (byte_dat == PS2_PREFIX_BRK) state_d = ST_F0;
          else begin
            push    = 1'b1;
            push_ev = '{ext: 1'b0, brk: 1'b0, code: byte_dat};
          end
        end
        ST_E0: begin
          if (byte_dat == PS2_PREFIX_BRK) state_d = ST_E0F0;
          else if (byte_dat != PS2_PREFIX_EXT) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b1, brk: 1'b0, code: byte_dat};
            state_d = ST_IDLE;
          end
        end
        ST_F0: begin
          push    = 1'b1;
          push_ev = '{ext: 1'b0, brk: 1'b1, code: byte_dat};
          state_d = ST_IDLE;
        end
        default: begin
          push    = 1'b1;
          push_ev = '{ext: 1'b1, brk: 1'b1, code: byte_dat};
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  kbd_event_t  mem_q [DEPTH];
  kbd_event_t  mem_d [DEPTH];
  logic        ovf_q, ovf_d;
  logic        empty, full, pop_ok, push_ok, drop;
  kbd_event_t  head;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_ok  = rd_en & ~empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    push_ok = push & (~full | pop_ok);
    drop    = push & full & ~pop_ok;
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = push_ev;
    wr_d    = wr_q + (AW+1)'(push_ok);
    rd_d    = rd_q + (AW+1)'(pop_ok);
    if (drop | par_err) ovf_d = 1'b1;
    else if (clr_ovf)   ovf_d = 1'b0;
    else                ovf_d = ovf_q;
    head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    key_data                = '0;
    key_data[KBD_VALID_BIT] = ~empty;
    key_data[KBD_OVF_BIT]   = ovf_q;
    key_data[9:0]           = head;
  end

  assign key_valid = ~empty;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_kbd_scan_fifo.sv
// Directed bench for kbd_scan_fifo: bit-banged PS/2 frames, table of prefix cases, FIFO corner sequences.
module tb_kbd_scan_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] key_data;
  logic        key_valid;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  kbd_scan_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .key_data  (key_data),
    .key_valid (key_valid),
    .ovf       (ovf)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          n;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(posedge clock);
    #1 ps2_clk = 1'b0;
    repeat (4) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_rdy,
                            input bit clr_rdy, input bit chk_lat);
    logic        par;
    logic [10:0] f;
    par = (~^b) ^ bad_par;
    f   = {1'b1, par, b, 1'b0};
    send_bits(f, 10);
    ps2_data = 1'b1;
    repeat (4) @(posedge clock);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    if (chk_lat) chk("latency_n1_not_valid", {15'b0, key_valid}, 16'h0000);
    rd_en   = pop_rdy;
    clr_ovf = clr_rdy;
    @(posedge clock);
    #1;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    if (chk_lat) chk("latency_n2_valid", {15'b0, key_valid}, 16'h0001);
    repeat (3) @(posedge clock);
    #1 ps2_clk = 1'b1;
    wait_cycles(4);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clock);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_ovf = 1'b1;
    @(posedge clock);
    #1 clr_ovf = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{b0: 8'h1C, b1: 8'h00, b2: 8'h00, n: 1, exp: 16'h801C};
    vecs[1] = '{b0: 8'hF0, b1: 8'h1C, b2: 8'h00, n: 2, exp: 16'h811C};
    vecs[2] = '{b0: 8'hE0, b1: 8'h75, b2: 8'h00, n: 2, exp: 16'h8275};
    vecs[3] = '{b0: 8'hE0, b1: 8'hF0, b2: 8'h75, n: 3, exp: 16'h8375};
    vecs[4] = '{b0: 8'hE0, b1: 8'hE0, b2: 8'h6B, n: 3, exp: 16'h826B};
    vecs[5] = '{b0: 8'hF0, b1: 8'hE0, b2: 8'h00, n: 2, exp: 16'h81E0};
    vecs[6] = '{b0: 8'h5A, b1: 8'h00, b2: 8'h00, n: 1, exp: 16'h805A};

    wait_cycles(3);
    chk("reset_key_data", key_data, 16'h0000);
    chk("reset_valid_ovf", {14'b0, key_valid, ovf}, 16'h0000);
    reset = 1'b1;
    wait_cycles(3);
    chk("post_reset_key_data", key_data, 16'h0000);

    // Single make code with exact key_valid latency
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_head", key_data, 16'h801C);
    pop();
    chk("t1_after_pop", key_data, 16'h0000);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (vecs[i].n > 1) send_frame(vecs[i].b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (vecs[i].n > 2) send_frame(vecs[i].b2, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_head", i), key_data, vecs[i].exp);
      pop();
      chk($sformatf("vec%0d_empty", i), key_data, 16'h0000);
    end

    // Overflow: 17 pushes into 16 entries
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf_head", key_data, 16'hC001);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("t3_pop%0d", i), key_data, 16'hC000 | 16'(i));
      pop();
    end
    chk("t3_drained", key_data, 16'h4000);
    pop();
    chk("t3_pop_empty_ignored", key_data, 16'h4000);
    pulse_clr();
    chk("t3_clr_ovf", key_data, 16'h0000);

    // Full FIFO: simultaneous push/pop, then set-wins over clr_ovf
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_full_head", key_data, 16'h8020);
    send_frame(8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_full_push_pop", key_data, 16'h8021);
    send_frame(8'h31, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_set_wins", key_data, 16'hC021);
    pulse_clr();
    chk("t4_clr_ovf", key_data, 16'h8021);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_pop%0d", i), key_data, 16'h8000 | 16'(8'h21 + 8'(i)));
      pop();
    end
    chk("t4_drained", key_data, 16'h0000);

    // Partial frame abandoned by timeout
    send_bits(11'b111_1111_1110, 5);
    wait_cycles(2100);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_after_timeout", key_data, 16'h8029);
    pop();
    chk("t5_single_entry", key_data, 16'h0000);

    // Push with pop on an empty FIFO: pop ignored
    send_frame(8'h44, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("empty_push_pop", key_data, 16'h8044);
    pop();
    chk("empty_push_pop_drain", key_data, 16'h0000);

    // Reset after an E0 prefix and mid-frame
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(11'b000_0000_0010, 3);
    ps2_data = 1'b1;
    reset = 1'b0;
    wait_cycles(3);
    chk("t6_in_reset", key_data, 16'h0000);
    reset = 1'b1;
    wait_cycles(3);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_prefix_cleared", key_data, 16'h8075);
    pop();
    chk("t6_drained", key_data, 16'h0000);

    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef KBD_PARITY_CHECK_EN
    chk("parity_err_dropped", key_data, 16'h4000);
    pulse_clr();
    chk("parity_err_clr", key_data, 16'h0000);
`else
    chk("parity_ignored", key_data, 16'h8033);
    pop();
    chk("parity_ignored_drain", key_data, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
